// File: rtl/layer_calc_array.sv
// ---------------------------------------------------------------------------
// layer_calc_array
//   Parametrised layer datapath. LANES signed MAC lanes share one weight per
//   beat. TAPS beats are accumulated per output window. The accumulator is
//   then arithmetically shifted right by FRAC, saturated to DW bits and
//   presented on a valid/ready output column.
//
//   Optional feature macro: LAYER_RELU_EN
//     defined   : negative saturated results are forced to zero
//     undefined : the signed saturated result is output unchanged
//
// Ports
//   clk        in   1                rising-edge clock
//   reset      in   1                asynchronous, active-low reset
//   clear      in   1                sync abort: drop partial window
//   in_valid   in   1                pixels/weight beat valid
//   in_ready   out  1                block can accept a beat
//   pixels     in   LANES*DW         lane i = pixels[i*DW +: DW]
//   weight     in   DW               weight shared by all lanes
//   out_valid  out  1                column holds a completed window
//   out_ready  in   1                downstream accepts the column
//   column     out  LANES*DW         lane i = column[i*DW +: DW]
//   tap_cnt    out  $clog2(TAPS+1)   beats accepted in the current window
// ---------------------------------------------------------------------------
module layer_calc_array #(
  parameter int LANES = 10,
  parameter int DW    = 16,
  parameter int TAPS  = 9,
  parameter int FRAC  = 8,
  parameter int ACCW  = 2*DW + $clog2(TAPS) + 1,
  parameter int CW    = $clog2(TAPS+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] pixels,
  input  logic [DW-1:0]       weight,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] column,
  output logic [CW-1:0]       tap_cnt
);

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  // Saturation bounds expressed at accumulator width, and the matching
  // output words.
  localparam logic signed [ACCW-1:0] SAT_MAX  = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN  = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]          MAX_WORD = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]          MIN_WORD = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CW-1:0]          TAP_LAST = CW'(TAPS-1);
  localparam logic [CW-1:0]          TAP_FULL = CW'(TAPS);

  state_t              r_state;
  logic                r_inReady;
  logic                r_outValid;
  logic [LANES*DW-1:0] r_column;
  logic [CW-1:0]       r_tapCnt;
  logic [1:0]          r_drainCnt;
  logic [DW-1:0]       r_w1;
  logic                r_v1;
  logic [LANES*DW-1:0] w_sat;
  logic                w_accept;
  logic                w_accClear;

  // A beat offered in a clear cycle is discarded, so clear gates acceptance.
  assign w_accept   = in_valid && r_inReady && !clear;
  // Accumulators restart on abort and when the finished column is taken.
  assign w_accClear = clear || ((r_state == ST_HOLD) && out_ready);

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign column    = r_column;
  assign tap_cnt   = r_tapCnt;

  // Stage-1 weight register and the beat-valid flag that launches the
  // multiply-accumulate on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_w1 <= weight;
      end
    end
  end

  // Per-lane datapath: stage-1 pixel, signed product, accumulator, then
  // shift and saturation of the accumulated value.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic        [DW-1:0]   r_p1;
    logic signed [ACCW-1:0] r_acc;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_shift;
    logic        [DW-1:0]   w_lane;

    // Operands are sign-extended to full product width so the multiply is
    // exact in two's complement.
    assign w_prod  = $signed({{DW{r_p1[DW-1]}}, r_p1}) * $signed({{DW{r_w1[DW-1]}}, r_w1});
    assign w_shift = r_acc >>> FRAC;
    assign w_lane  = (w_shift > SAT_MAX) ? MAX_WORD :
                     (w_shift < SAT_MIN) ? MIN_WORD : w_shift[DW-1:0];

`ifdef LAYER_RELU_EN
    assign w_sat[gi*DW +: DW] = w_lane[DW-1] ? '0 : w_lane;
`else
    assign w_sat[gi*DW +: DW] = w_lane;
`endif

    // Pixel capture and accumulation; a clear or column hand-off zeroes the
    // sum and wins over any product landing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_p1  <= '0;
        r_acc <= '0;
      end else begin
        if (w_accept) begin
          r_p1 <= pixels[gi*DW +: DW];
        end
        if (w_accClear) begin
          r_acc <= '0;
        end else if (r_v1) begin
          r_acc <= r_acc + {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
        end
      end
    end
  end

  // Window control. ACCUM counts beats; DRAIN waits two cycles so the last
  // product has settled in the accumulators before the column is registered;
  // HOLD keeps the column until downstream takes it. clear overrides all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_ACCUM;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_column   <= '0;
      r_tapCnt   <= '0;
      r_drainCnt <= '0;
    end else if (clear) begin
      r_state    <= ST_ACCUM;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_tapCnt   <= '0;
      r_drainCnt <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (in_valid) begin
            if (r_tapCnt == TAP_LAST) begin
              r_tapCnt   <= TAP_FULL;
              r_inReady  <= 1'b0;
              r_drainCnt <= '0;
              r_state    <= ST_DRAIN;
            end else begin
              r_tapCnt <= r_tapCnt + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_drainCnt == 2'd2) begin
            r_column   <= w_sat;
            r_outValid <= 1'b1;
            r_state    <= ST_HOLD;
          end else begin
            r_drainCnt <= r_drainCnt + 2'd1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_tapCnt   <= '0;
            r_inReady  <= 1'b1;
            r_state    <= ST_ACCUM;
          end
        end
        default: begin
          r_state   <= ST_ACCUM;
          r_inReady <= 1'b1;
        end
      endcase
    end
  end

endmodule
